// File: rtl/addsub_acc_unit_if.sv
// Operand/result handshake bundle for addsub_acc_unit.
// master = operand source / result consumer side, slave = the arithmetic unit.
interface addsub_acc_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;
  logic             zero;
  logic             neg;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, mode, a, b, c_in, out_ready,
    input  in_ready, out_valid, result, c_out, ovf, zero, neg, acc
  );

  modport slave (
    input  in_valid, mode, a, b, c_in, out_ready,
    output in_ready, out_valid, result, c_out, ovf, zero, neg, acc
  );
endinterface

// File: rtl/addsub_acc_unit.sv
// addsub_acc_unit: registered add/subtract/accumulate/load unit with valid/ready
// on both sides, status flags and a persistent accumulator. One-beat output
// register giving full throughput when the consumer keeps out_ready high.
// Optional feature macro: ADDSUB_SAT_EN (saturate on signed overflow).
module addsub_acc_unit #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  addsub_acc_unit_if.slave   bus
);

  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             accept_c;
  mode_e            mode_c;
  logic [WIDTH-1:0] op_a_c;
  logic [WIDTH-1:0] op_b_c;
  logic [WIDTH:0]   sum_c;
  logic             sovf_c;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             flag_ovf_c;

  assign bus.in_ready  = (state_q == S_EMPTY) | bus.out_ready;
  assign accept_c      = bus.in_valid & bus.in_ready;
  assign mode_c        = mode_e'(bus.mode);

  assign bus.out_valid = (state_q == S_FULL);
  assign bus.result    = result_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.acc       = acc_q;

  // Operand selection, WIDTH+1 bit sum, signed overflow and optional clamp
  always_comb begin
    op_a_c     = bus.a;
    op_b_c     = bus.b;
    case (mode_c)
      MODE_SUB: op_b_c = ~bus.b;
      MODE_ACC: begin
        op_a_c = acc_q;
        op_b_c = bus.a;
      end
      default: ;
    endcase

    sum_c  = {1'b0, op_a_c} + {1'b0, op_b_c} + (WIDTH + 1)'(bus.c_in);
    sovf_c = (op_a_c[MSB] == op_b_c[MSB]) & (sum_c[MSB] != op_a_c[MSB]);

`ifdef ADDSUB_SAT_EN
    // Overflow direction follows the common operand sign
    if (sovf_c) begin
      res_c = op_a_c[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_c = sum_c[WIDTH-1:0];
    end
`else
    res_c = sum_c[WIDTH-1:0];
`endif
    carry_c    = sum_c[WIDTH];
    flag_ovf_c = sovf_c;

    if (mode_c == MODE_LOAD) begin
      res_c      = bus.a;
      carry_c    = 1'b0;
      flag_ovf_c = 1'b0;
    end
  end

  // Output-register occupancy FSM and next-state of result/flags/accumulator
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    acc_d    = acc_q;

    case (state_q)
      S_EMPTY: if (accept_c) state_d = S_FULL;
      S_FULL: begin
        if (!accept_c && bus.out_ready) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase

    if (accept_c) begin
      result_d = res_c;
      c_out_d  = carry_c;
      ovf_d    = flag_ovf_c;
      zero_d   = (res_c == '0);
      neg_d    = res_c[MSB];
      if (mode_c == MODE_ACC || mode_c == MODE_LOAD) acc_d = res_c;
    end
  end

  // State, result, flags and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      acc_q    <= ACC_INIT;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_addsub_acc_unit.sv
// Self-checking bench for addsub_acc_unit: directed steps plus a random
// handshake run, scored against a queue of expected beats from a signed model.
// A second WIDTH=4 instance covers the narrow-width arithmetic.
module tb_addsub_acc_unit;

  localparam logic [7:0] ACC_INIT = 8'h5A;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
    logic [7:0] acc;
  } exp_t;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;
  int n_accept = 0;

  exp_t       sb[$];
  logic [7:0] model_acc;
  logic [7:0] hold_r;

  addsub_acc_unit_if #(.WIDTH(8)) bus ();
  addsub_acc_unit_if #(.WIDTH(4)) bus4 ();

  addsub_acc_unit #(.WIDTH(8), .ACC_INIT(ACC_INIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  addsub_acc_unit #(.WIDTH(4), .ACC_INIT(4'h0)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic using signed integer range for overflow
  function automatic exp_t model(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                                 input logic ci, input logic [7:0] acc_in);
    exp_t       e;
    logic [7:0] opa;
    logic [7:0] opb;
    int         s;
    int         sa;
    int         sb2;
    int         ss;
    e.acc = acc_in;
    if (m == 2'b11) begin
      e.r   = a;
      e.c   = 1'b0;
      e.v   = 1'b0;
      e.acc = a;
    end else begin
      opa = (m == 2'b10) ? acc_in : a;
      opb = (m == 2'b00) ? b : ((m == 2'b01) ? ~b : a);
      s   = int'(opa) + int'(opb) + int'(ci);
      e.c = s[8];
      e.r = s[7:0];
      sa  = $signed(opa);
      sb2 = $signed(opb);
      ss  = sa + sb2 + int'(ci);
      e.v = (ss > 127) || (ss < -128);
`ifdef ADDSUB_SAT_EN
      if (ss > 127)       e.r = 8'h7F;
      else if (ss < -128) e.r = 8'h80;
`endif
      if (m == 2'b10) e.acc = e.r;
    end
    e.z = (e.r == 8'h00);
    e.n = e.r[7];
    return e;
  endfunction

  // One clock: check handshake, score a consumed beat, log an accepted beat
  task automatic tick();
    exp_t e;
    logic exp_ready;
    logic acc_now;
    #1;
    exp_ready = (sb.size() == 0) || bus.out_ready;
    check("out_valid", bus.out_valid, sb.size() != 0);
    check("in_ready", bus.in_ready, exp_ready);
    acc_now = bus.in_valid && exp_ready;
    if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
      e = sb.pop_front();
      check("sb_beat", {bus.result, bus.c_out, bus.ovf, bus.zero, bus.neg, bus.acc}, e);
    end
    if (acc_now) begin
      e = model(bus.mode, bus.a, bus.b, bus.c_in, model_acc);
      model_acc = e.acc;
      sb.push_back(e);
      n_accept++;
    end
    @(negedge clk);
  endtask

  task automatic beat(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b, input logic ci);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = ci;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_result"}, bus.result, 8'h00);
    check({tag, "_flags"}, {bus.c_out, bus.ovf, bus.zero, bus.neg}, 4'b0010);
    check({tag, "_acc"}, bus.acc, ACC_INIT);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mode      = 2'b00;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.mode      = 2'b00;
    bus4.a         = 4'h0;
    bus4.b         = 4'h0;
    bus4.c_in      = 1'b0;
    bus4.out_ready = 1'b1;
    model_acc     = ACC_INIT;

    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_state("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Signed overflow on ADD
    beat(2'b00, 8'h7F, 8'h01, 1'b0);
`ifdef ADDSUB_SAT_EN
    check("add_ovf_result", bus.result, 8'h7F);
    check("add_ovf_neg", bus.neg, 1'b0);
`else
    check("add_ovf_result", bus.result, 8'h80);
    check("add_ovf_neg", bus.neg, 1'b1);
`endif
    check("add_ovf_cout", bus.c_out, 1'b0);
    check("add_ovf_ovf", bus.ovf, 1'b1);
    tick();

    // SUB with borrow, then equal operands back to back
    beat(2'b01, 8'h05, 8'h07, 1'b1);
    check("sub_borrow", {bus.result, bus.c_out, bus.neg, bus.ovf}, {8'hFE, 3'b010});
    beat(2'b01, 8'h07, 8'h07, 1'b1);
    check("sub_zero", {bus.result, bus.zero, bus.c_out}, {8'h00, 2'b11});
    tick();

    // LOAD then ACC twice with an ADD in between
    beat(2'b11, 8'hF0, 8'hAA, 1'b1);
    check("load_acc", bus.acc, 8'hF0);
    check("load_flags", {bus.result, bus.c_out, bus.ovf}, {8'hF0, 2'b00});
    beat(2'b10, 8'h20, 8'h99, 1'b0);
    check("acc1", {bus.acc, bus.result, bus.c_out}, {8'h10, 8'h10, 1'b1});
    beat(2'b00, 8'h03, 8'h04, 1'b0);
    check("acc_hold_add", {bus.acc, bus.result}, {8'h10, 8'h07});
    beat(2'b10, 8'h20, 8'h00, 1'b0);
    check("acc2", {bus.acc, bus.result, bus.c_out}, {8'h30, 8'h30, 1'b0});
    tick();

    // Backpressure: result must freeze while the consumer stalls
    bus.out_ready = 1'b0;
    beat(2'b00, 8'h11, 8'h22, 1'b0);
    hold_r = bus.result;
    check("bp_first", hold_r, 8'h33);
    bus.in_valid = 1'b1;
    bus.a        = 8'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_stable", bus.result, hold_r);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_next", bus.result, 8'h62);
    bus.in_valid = 1'b0;
    tick();

    // Random traffic with random backpressure
    n_accept = 0;
    for (int cyc = 0; cyc < 3000 && n_accept < 100; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.mode      = 2'($urandom_range(0, 3));
      bus.a         = 8'($urandom);
      bus.b         = 8'($urandom);
      bus.c_in      = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    check("rand_budget", n_accept >= 100, 1'b1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("drain", sb.size(), 0);

    // Asynchronous reset while a beat is pending
    beat(2'b10, 8'h01, 8'h02, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    sb.delete();
    model_acc = ACC_INIT;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(2'b10, 8'h01, 8'h00, 1'b1);
    check("post_rst_acc", bus.acc, 8'h5C);
    tick();

    // Narrow instance arithmetic
    bus4.in_valid = 1'b1;
    bus4.mode     = 2'b00;
    bus4.a        = 4'b1011;
    bus4.b        = 4'b0110;
    bus4.c_in     = 1'b1;
    @(negedge clk);
    check("w4_add", {bus4.result, bus4.c_out}, {4'b0010, 1'b1});
    bus4.mode = 2'b01;
    @(negedge clk);
    check("w4_sub", {bus4.result, bus4.c_out}, {4'b0101, 1'b1});
    bus4.in_valid = 1'b0;
    @(negedge clk);
    check("w4_idle", bus4.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
